// File: rtl/tick_scheduler.sv
// tick_scheduler: per-channel single-cycle clock-enable strobes with aligned start and glitch-free rate changes
module tick_scheduler #(
  parameter int CH_NUM = 4,
  parameter int DIV_W  = 24,
  parameter int CH_W   = 2
) (
  input  logic              ts_clk,
  input  logic              ts_rst_n,
  input  logic              ts_start,
  input  logic              ts_stop,
  input  logic              ts_cfg_valid,
  output logic              ts_cfg_ready,
  input  logic [CH_W-1:0]   ts_cfg_ch,
  input  logic [DIV_W-1:0]  ts_cfg_div,
  input  logic [DIV_W-1:0]  ts_cfg_phase,
  output logic [CH_NUM-1:0] ts_tick,
  output logic              ts_running,
  output logic              ts_cfg_err
);
  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;
  state_t state, state_n;
  logic [1:0] rst_q;
  logic rst_n, ch_ok, acc, live, stopping, err_n;
  logic [CH_NUM-1:0] pend, tick_n;
  always_ff @(posedge ts_clk or negedge ts_rst_n)
    if (!ts_rst_n) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_n = rst_q[1];
  assign ch_ok = int'(ts_cfg_ch) < CH_NUM;
  assign ts_cfg_ready = state == IDLE || !ch_ok || !pend[ts_cfg_ch];
  assign acc = ts_cfg_valid && ts_cfg_ready;
  assign live = state != IDLE;
  assign stopping = live && ts_stop;
  assign ts_running = live;
  always_comb begin
    state_n = state == IDLE ? (ts_start && !ts_stop ? ALIGN : IDLE) : ts_stop ? IDLE : RUN;
    err_n = (acc && !ch_ok) || (ts_cfg_err && state != ALIGN);
  end
  always_ff @(posedge ts_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ts_tick <= '0;
      ts_cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      ts_tick <= tick_n;
      ts_cfg_err <= err_n;
    end
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [DIV_W-1:0] d, p, sd, sp, cnt, d_n, cnt_n;
    logic pnd, wr, wr_sh, tc, commit;
    assign wr = acc && ts_cfg_ch == CH_W'(c);
    assign wr_sh = wr && live;
    assign tc = d != '0 && cnt == d - DIV_W'(1);
    // a stop folds any pending or same-cycle write straight into the active set
    assign commit = (state == RUN && pnd && (tc || d == '0)) || (stopping && (pnd || wr_sh));
    assign d_n = wr && (!live || commit) ? ts_cfg_div : commit ? sd : d;
    assign cnt_n = state == ALIGN ? (d == '0 ? '0 : p < d ? p : d - DIV_W'(1))
                 : state != RUN ? cnt
                 : commit || tc || d == '0 ? '0 : cnt + DIV_W'(1);
    // tick is registered: decode the terminal count of the next cycle's counter
    assign tick_n[c] = state_n == RUN && d_n != '0 && cnt_n == d_n - DIV_W'(1);
    assign pend[c] = pnd;
    always_ff @(posedge ts_clk or negedge rst_n)
      if (!rst_n) begin
        d <= '0;
        p <= '0;
        sd <= '0;
        sp <= '0;
        cnt <= '0;
        pnd <= 1'b0;
      end else begin
        d <= d_n;
        p <= wr && (!live || commit) ? ts_cfg_phase : commit ? sp : p;
        sd <= wr_sh ? ts_cfg_div : sd;
        sp <= wr_sh ? ts_cfg_phase : sp;
        cnt <= cnt_n;
        pnd <= !commit && (pnd || wr_sh);
      end
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed and random stimulus checked against an absolute-time tick schedule model
module tb_tick_scheduler;
  logic ts_clk = 0, ts_rst_n = 0, ts_start = 0, ts_stop = 0, ts_cfg_valid = 0;
  logic [1:0] ts_cfg_ch = 0;
  logic [23:0] ts_cfg_div = 0, ts_cfg_phase = 0;
  logic ts_cfg_ready, ts_running, ts_cfg_err;
  logic [3:0] ts_tick;
  logic rdy3, run3, err3;
  logic [2:0] tick3;
  int checks = 0, failures = 0;
  int md[4], mp[4], msd[4], msp[4], mnext[4];
  bit mpend[4];
  int mst = 0, rt = 0;
  bit merr3 = 0, stall = 0;
  int tq[4][$];
  int a1, a2;

  tick_scheduler dut (.ts_clk(ts_clk), .ts_rst_n(ts_rst_n), .ts_start(ts_start), .ts_stop(ts_stop),
    .ts_cfg_valid(ts_cfg_valid), .ts_cfg_ready(ts_cfg_ready), .ts_cfg_ch(ts_cfg_ch),
    .ts_cfg_div(ts_cfg_div), .ts_cfg_phase(ts_cfg_phase), .ts_tick(ts_tick),
    .ts_running(ts_running), .ts_cfg_err(ts_cfg_err));

  // three-channel copy so that channel index 3 is out of range
  tick_scheduler #(.CH_NUM(3)) dut3 (.ts_clk(ts_clk), .ts_rst_n(ts_rst_n), .ts_start(ts_start),
    .ts_stop(ts_stop), .ts_cfg_valid(ts_cfg_valid), .ts_cfg_ready(rdy3), .ts_cfg_ch(ts_cfg_ch),
    .ts_cfg_div(ts_cfg_div), .ts_cfg_phase(ts_cfg_phase), .ts_tick(tick3),
    .ts_running(run3), .ts_cfg_err(err3));

  always #5 ts_clk = ~ts_clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin
      md[i] = 0; mp[i] = 0; msd[i] = 0; msp[i] = 0; mnext[i] = 0; mpend[i] = 0;
    end
    mst = 0; rt = 0; merr3 = 0; stall = 0;
  endtask

  task automatic mcommit(int i);
    md[i] = msd[i]; mp[i] = msp[i]; mpend[i] = 0;
  endtask

  task automatic mstep(bit er);
    bit acc = ts_cfg_valid && er;
    int ch = int'(ts_cfg_ch);
    if (mst == 0) begin
      if (acc) begin md[ch] = int'(ts_cfg_div); mp[ch] = int'(ts_cfg_phase); end
      if (ts_start && !ts_stop) mst = 1;
    end else if (mst == 1) begin
      merr3 = 0;
      if (ts_stop) mst = 0;
      else begin
        mst = 2; rt = 0;
        for (int i = 0; i < 4; i++)
          if (md[i] > 0) mnext[i] = md[i] - 1 - (mp[i] < md[i] - 1 ? mp[i] : md[i] - 1);
      end
    end else begin
      for (int i = 0; i < 4; i++)
        if ((md[i] > 0 && rt == mnext[i]) || (md[i] == 0 && mpend[i])) begin
          if (mpend[i]) mcommit(i);
          mnext[i] = rt + md[i];
        end
      if (acc) begin msd[ch] = int'(ts_cfg_div); msp[ch] = int'(ts_cfg_phase); mpend[ch] = 1; end
      if (ts_stop) begin
        for (int i = 0; i < 4; i++) if (mpend[i]) mcommit(i);
        mst = 0;
      end
      rt++;
    end
    if (ts_cfg_valid && ts_cfg_ch == 2'd3) merr3 = 1;
  endtask

  always @(negedge ts_clk) begin
    logic [3:0] et;
    bit er;
    if (!ts_rst_n) mreset();
    for (int i = 0; i < 4; i++) et[i] = mst == 2 && md[i] > 0 && rt == mnext[i];
    er = mst == 0 || !mpend[ts_cfg_ch];
    chk("tick", 32'(ts_tick), 32'(et));
    chk("running", 32'(ts_running), 32'(mst != 0));
    chk("ready", 32'(ts_cfg_ready), 32'(er));
    chk("err", 32'(ts_cfg_err), 0);
    chk("tick3", 32'(tick3), 32'(et[2:0]));
    chk("running3", 32'(run3), 32'(mst != 0));
    chk("ready3", 32'(rdy3), 32'(ts_cfg_ch == 2'd3 || er));
    chk("err3", 32'(err3), 32'(merr3));
    if (mst == 2) for (int i = 0; i < 4; i++) if (ts_tick[i]) tq[i].push_back(rt);
    stall = ts_cfg_valid && !er;
    if (ts_rst_n) mstep(er);
  end

  task automatic step();
    @(posedge ts_clk);
    #1;
  endtask

  task automatic clrq();
    for (int i = 0; i < 4; i++) tq[i].delete();
  endtask

  function automatic int qv(int i, int k);
    return tq[i].size() > k ? tq[i][k] : -1;
  endfunction

  task automatic wr(int ch, int dv, int ph, output int at);
    int n = 0;
    ts_cfg_valid = 1; ts_cfg_ch = 2'(ch); ts_cfg_div = 24'(dv); ts_cfg_phase = 24'(ph);
    #1;
    while (!ts_cfg_ready && n < 64) begin step(); #1; n++; end
    if (n == 64) chk("wr_timeout", 32'(ts_cfg_ready), 1);
    at = rt;
    step();
    ts_cfg_valid = 0;
  endtask

  task automatic pulse_start();
    clrq();
    ts_start = 1; step(); ts_start = 0;
  endtask

  task automatic do_stop();
    ts_stop = 1; step(); ts_stop = 0; step();
  endtask

  task automatic wait_t(int n);
    int g = 0;
    while (!(mst == 2 && rt == n) && g < 200) begin step(); g++; end
    if (g == 200) chk("wait_t_timeout", 32'(rt), 32'(n));
  endtask

  task automatic rnd_wr();
    ts_cfg_valid = 1;
    ts_cfg_ch = 2'($urandom_range(3));
    ts_cfg_div = 24'($urandom_range(9));
    ts_cfg_phase = 24'($urandom_range(12));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    ts_rst_n = 1;
    repeat (5) step();
    // basic rates
    wr(0, 1, 0, a1); wr(1, 5, 0, a1); wr(2, 10, 3, a1); wr(3, 0, 0, a1);
    pulse_start();
    repeat (32) step();
    chk("b_c0_first", 32'(qv(0, 0)), 0);
    chk("b_c0_tenth", 32'(qv(0, 9)), 9);
    chk("b_c1_0", 32'(qv(1, 0)), 4);
    chk("b_c1_1", 32'(qv(1, 1)), 9);
    chk("b_c1_2", 32'(qv(1, 2)), 14);
    chk("b_c2_0", 32'(qv(2, 0)), 6);
    chk("b_c2_1", 32'(qv(2, 1)), 16);
    chk("b_c2_2", 32'(qv(2, 2)), 26);
    chk("b_c3_none", 32'(tq[3].size()), 0);
    // async reset mid-run
    chk("pre_rst_tick0", 32'(ts_tick[0]), 1);
    #1 ts_rst_n = 0;
    #1;
    chk("rst_tick", 32'(ts_tick), 0);
    chk("rst_running", 32'(ts_running), 0);
    repeat (3) step();
    ts_rst_n = 1;
    #1;
    chk("post_rst_ready", 32'(ts_cfg_ready), 1);
    repeat (100) step();
    // phase clamp
    wr(1, 4, 9, a1);
    pulse_start();
    repeat (14) step();
    chk("pc_0", 32'(qv(1, 0)), 0);
    chk("pc_1", 32'(qv(1, 1)), 4);
    chk("pc_2", 32'(qv(1, 2)), 8);
    // glitch-free rate change
    do_stop();
    wr(1, 5, 0, a1);
    pulse_start();
    wait_t(6);
    wr(1, 3, 0, a1);
    chk("g_accept", 32'(a1), 6);
    for (int k = 7; k <= 10; k++) begin
      #1;
      chk("g_ready", 32'(ts_cfg_ready), 32'(k == 10));
      step();
    end
    wait_t(17);
    chk("g_0", 32'(qv(1, 0)), 4);
    chk("g_1", 32'(qv(1, 1)), 9);
    chk("g_2", 32'(qv(1, 2)), 12);
    chk("g_3", 32'(qv(1, 3)), 15);
    // back-to-back writes stall until terminal count
    do_stop();
    wr(2, 6, 0, a1);
    pulse_start();
    wait_t(1);
    wr(2, 4, 0, a1);
    wr(2, 2, 0, a2);
    chk("bp_first", 32'(a1), 1);
    chk("bp_second", 32'(a2), 6);
    wait_t(15);
    chk("bp_0", 32'(qv(2, 0)), 5);
    chk("bp_1", 32'(qv(2, 1)), 9);
    chk("bp_2", 32'(qv(2, 2)), 11);
    chk("bp_3", 32'(qv(2, 3)), 13);
    // out-of-range channel on the three-channel copy
    wr(3, 7, 0, a1);
    chk("err3_set", 32'(err3), 1);
    do_stop();
    chk("err3_sticky", 32'(err3), 1);
    pulse_start();
    step();
    chk("err3_clear", 32'(err3), 0);
    // stop with a pending write
    do_stop();
    wr(1, 8, 0, a1);
    pulse_start();
    wait_t(16);
    wr(1, 3, 0, a1);
    chk("sp_accept", 32'(a1), 16);
    wait_t(20);
    ts_stop = 1; step(); ts_stop = 0;
    chk("sp_tick", 32'(ts_tick), 0);
    chk("sp_running", 32'(ts_running), 0);
    pulse_start();
    repeat (12) step();
    chk("sp_0", 32'(qv(1, 0)), 2);
    chk("sp_1", 32'(qv(1, 1)), 5);
    chk("sp_2", 32'(qv(1, 2)), 8);
    // start and stop together in IDLE
    do_stop();
    ts_start = 1; ts_stop = 1; step(); ts_start = 0; ts_stop = 0;
    chk("ss_idle", 32'(ts_running), 0);
    step();
    // random traffic
    for (int k = 0; k < 4000; k++) begin
      ts_start = 0; ts_stop = 0;
      if (!stall) ts_cfg_valid = 0;
      if (mst == 0) begin
        if ($urandom_range(7) == 0) begin ts_start = 1; ts_stop = $urandom_range(3) == 0; end
        if (!stall && $urandom_range(3) == 0) rnd_wr();
      end else if (mst == 1) begin
        if ($urandom_range(15) == 0) ts_stop = 1;
      end else begin
        if (!stall && $urandom_range(3) == 0) rnd_wr();
        if ($urandom_range(60) == 0) ts_stop = 1;
      end
      step();
    end
    ts_cfg_valid = 0; ts_start = 0; ts_stop = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Generates per-channel single-cycle clock-enable strobes ("ticks") from the single fundamental clock. It replaces ripple-divided clocks with enables on one clock domain.
- Sits between the clock hub / bench fundamental clock and the sampling logic. It sequences start/stop, phase alignment, and glitch-free run-time reconfiguration of each channel's rate.

Parameters:
- CH_NUM, 4, number of tick channels.
- DIV_W, 24, width of divider and phase values (max period 2^DIV_W-1 cycles).
- CH_W, 2, width of channel index (must hold CH_NUM-1).

Ports:
- ts_clk  input  1  fundamental clock (50 MHz nominal).
- ts_rst_n  input  1  asynchronous active-low reset.
- ts_start  input  1  pulse: begin run from IDLE.
- ts_stop  input  1  pulse: end run, return to IDLE.
- ts_cfg_valid  input  1  config write request.
- ts_cfg_ready  output  1  config write can be accepted this cycle.
- ts_cfg_ch  input  CH_W  target channel.
- ts_cfg_div  input  DIV_W  period D in cycles; 0 = channel disabled.
- ts_cfg_phase  input  DIV_W  start offset p.
- ts_tick  output  CH_NUM  per-channel one-cycle strobes.
- ts_running  output  1  high in ALIGN and RUN.
- ts_cfg_err  output  1  sticky: write to channel index >= CH_NUM.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - state=IDLE; all active/shadow D, p, counters and pending flags = 0.
  - ts_tick=0, ts_running=0, ts_cfg_err=0, ts_cfg_ready=1.
- Handshake:
  - A write is accepted when ts_cfg_valid && ts_cfg_ready.
  - The requester holds ch/div/phase stable while valid and not ready.
- FSM: IDLE -> ALIGN -> RUN -> IDLE.
  - IDLE:
    - Ticks are 0 and counters are held.
    - Accepted writes go directly to the active D/p of the channel; ts_cfg_ready=1.
    - ts_start -> ALIGN.
    - ts_start && ts_stop in the same cycle: stays IDLE.
  - ALIGN (exactly 1 cycle):
    - cnt[i] <= min(p[i], D[i]-1), or 0 if D[i]=0.
    - ts_cfg_err cleared; ticks 0.
    - Goes to RUN, unless ts_stop, which goes to IDLE.
  - RUN:
    - Cycle 0 is the first RUN cycle.
    - For each channel with D>0: tick high in any cycle where cnt==D-1, then cnt wraps to 0; otherwise cnt+1.
    - The first tick therefore falls at cycle D-1-p, then every D cycles.
    - D=1 gives a tick every cycle. D=0 gives no tick and the counter is held at 0.
    - Ticks must be register-driven (no combinational path from inputs).
    - ts_start ignored.
    - ts_stop -> IDLE next cycle; ticks 0 from that cycle.
- Run-time reconfiguration (RUN only):
  - An accepted write goes to the channel shadow and sets pending[ch].
  - ts_cfg_ready = !pending[ts_cfg_ch] (or 1 if ts_cfg_ch >= CH_NUM).
  - Commit on the channel's terminal-count cycle: that tick still fires with the old D, then active <= shadow, cnt <= 0, pending cleared. This gives no short or long period.
  - If the active D=0, commit on the next cycle with cnt <= 0. The first tick follows after new D cycles.
  - A committed D=0 disables the channel after its final tick.
  - Phase in the shadow is stored but applied only at the next ALIGN.
- Invalid channel (ts_cfg_ch >= CH_NUM): the write is accepted, data discarded, ts_cfg_err set (sticky until next ALIGN or reset).
- Stop with pending writes: all shadows are committed to active in the stop cycle and pending is cleared.
- Write and stop in the same cycle: the write is treated as a RUN write, then committed with the stop.
- Reset mid-run: immediate IDLE; all config lost; ticks drop asynchronously.
- Counter widths: DIV_W; compare against D-1 computed in DIV_W bits (D>0 guaranteed at compare).

Test Plan:
- Reset values: assert ts_rst_n=0 mid-RUN -> ts_tick=0 and ts_running=0 within the same cycle; after release, ts_cfg_ready=1 and no ticks for 100 cycles without start.
- Basic rates: IDLE writes ch0 D=1, ch1 D=5 p=0, ch2 D=10 p=3, ch3 D=0; start -> ch0 ticks every cycle from cycle 0; ch1 at cycles 4, 9, 14; ch2 at cycles 6, 16, 26; ch3 never.
- Phase clamp: ch1 D=4 p=9 -> first tick at cycle 0, then 4, 8.
- Glitch-free change: ch1 D=5 running; write D=3 at cycle 6 -> tick at 9 (old period), next ticks 12, 15; ts_cfg_ready for ch1 low from cycle 7 until commit at cycle 9.
- Backpressure and error: two back-to-back RUN writes to ch2 -> second write stalls (ready=0) until ch2's terminal count. Write with ch index >= CH_NUM (only if CH_NUM < 2^CH_W) -> accepted, ts_cfg_err=1, no channel changes; the next start clears ts_cfg_err.
- Stop and simultaneous events: stop at cycle 20 with a pending ch1 write -> ticks 0 from cycle 21; a restart shows the new D active. start+stop in the same IDLE cycle -> remains IDLE, ts_running=0.
